// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of programmable clock-enable dividers. Each channel gives a square wave and
// an end-of-period tick; divisor updates land only at period boundaries, and a global sync realigns phase.
module clk_div_bank #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_en,
  input  logic                i_sync,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic [CH_W-1:0]     i_cfg_chan,
  input  logic [CNT_W-1:0]    i_cfg_div,
  output logic                o_cfg_err,
  output logic [CHANNELS-1:0] o_clk_slow,
  output logic [CHANNELS-1:0] o_tick
);

  logic [CHANNELS-1:0] w_hit;
  logic [CHANNELS-1:0] w_pend;
  logic                w_xfer;
  logic                w_bad;
  logic                r_err;

  // An out-of-range channel matches nothing, so it is always ready and always rejected.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_hit[i] = (i_cfg_chan == CH_W'(i));
    end
  end

  assign o_cfg_ready = ~|(w_hit & w_pend);
  assign w_xfer      = i_cfg_valid & o_cfg_ready;
  assign w_bad       = (i_cfg_div < CNT_W'(2)) | ~|w_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_xfer & w_bad;
    end
  end

  assign o_cfg_err = r_err;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pdiv;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pend;
    logic             r_slow;
    logic             r_tick;
    logic [CNT_W-1:0] w_div_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_last;
    logic             w_bound;
    logic             w_load;

    assign w_last  = (r_cnt == r_div - CNT_W'(1));
    assign w_bound = ~i_en[g] | i_sync | w_last;
    assign w_div_n = (w_bound & r_pend) ? r_pdiv : r_div;
    assign w_load  = w_xfer & w_hit[g] & ~w_bad;

    // Parking at D-1 while disabled makes the first enabled edge look like a natural wrap.
    always_comb begin
      w_cnt_n = r_cnt + CNT_W'(1);
      if (!i_en[g]) begin
        w_cnt_n = w_div_n - CNT_W'(1);
      end else if (w_bound) begin
        w_cnt_n = '0;
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_div  <= CNT_W'(DEFAULT_DIV);
        r_pdiv <= CNT_W'(DEFAULT_DIV);
        r_cnt  <= CNT_W'(DEFAULT_DIV - 1);
        r_pend <= 1'b0;
        r_slow <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        r_div  <= w_div_n;
        r_cnt  <= w_cnt_n;
        r_slow <= i_en[g] & (w_cnt_n < (w_div_n >> 1));
        r_tick <= i_en[g] & (w_cnt_n == w_div_n - CNT_W'(1));
        // A load can only happen with pend clear, so it never races an apply of the same channel.
        if (w_load) begin
          r_pdiv <= i_cfg_div;
          r_pend <= 1'b1;
        end else if (w_bound) begin
          r_pend <= 1'b0;
        end
      end
    end

    assign w_pend[g]     = r_pend;
    assign o_clk_slow[g] = r_slow;
    assign o_tick[g]     = r_tick;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: two instances (4 ch x 16 bit, 5 ch x 4 bit) checked every cycle
// against a phase/period reference model, plus directed scenarios with literal expectations.
module tb_clk_div_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  a_en = '0;
  logic        a_sync = 1'b0, a_valid = 1'b0;
  logic [1:0]  a_chan = '0;
  logic [15:0] a_div = '0;
  logic        a_ready, a_err;
  logic [3:0]  a_slow, a_tick;

  logic [4:0]  b_en = '0;
  logic        b_sync = 1'b0, b_valid = 1'b0;
  logic [2:0]  b_chan = '0;
  logic [3:0]  b_div = '0;
  logic        b_ready, b_err;
  logic [4:0]  b_slow, b_tick;

  clk_div_bank #(.CHANNELS(4), .CNT_W(16), .DEFAULT_DIV(2)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(a_en), .i_sync(a_sync),
    .i_cfg_valid(a_valid), .o_cfg_ready(a_ready), .i_cfg_chan(a_chan),
    .i_cfg_div(a_div), .o_cfg_err(a_err), .o_clk_slow(a_slow), .o_tick(a_tick));

  clk_div_bank #(.CHANNELS(5), .CNT_W(4), .DEFAULT_DIV(3)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(b_en), .i_sync(b_sync),
    .i_cfg_valid(b_valid), .o_cfg_ready(b_ready), .i_cfg_chan(b_chan),
    .i_cfg_div(b_div), .o_cfg_err(b_err), .o_clk_slow(b_slow), .o_tick(b_tick));

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per channel a period D, a phase within the period, and whether it ran last edge.
  int  nch[2]  = '{4, 5};
  int  dflt[2] = '{2, 3};
  int  m_d[2][5], m_pd[2][5], m_ph[2][5];
  bit  m_pend[2][5], m_run[2][5];
  bit  m_err[2];

  task automatic m_reset(input int k);
    for (int c = 0; c < 5; c++) begin
      m_d[k][c] = dflt[k]; m_pd[k][c] = dflt[k]; m_ph[k][c] = 0;
      m_pend[k][c] = 1'b0; m_run[k][c] = 1'b0;
    end
    m_err[k] = 1'b0;
  endtask

  function automatic bit m_ready(input int k, input int chan);
    if (chan >= nch[k]) return 1'b1;
    return !m_pend[k][chan];
  endfunction

  task automatic m_step(input int k, input logic [4:0] en, input bit sync, input bit valid,
                        input int chan, input int dv);
    bit rdy, rej, restart, wrapped;
    rdy = m_ready(k, chan);
    rej = (dv < 2) || (chan >= nch[k]);
    for (int c = 0; c < nch[k]; c++) begin
      restart = en[c] && (!m_run[k][c] || sync);
      wrapped = en[c] && m_run[k][c] && !sync && (m_ph[k][c] == m_d[k][c] - 1);
      if ((!en[c] || restart || wrapped) && m_pend[k][c]) begin
        m_d[k][c] = m_pd[k][c];
        m_pend[k][c] = 1'b0;
      end
      if (en[c]) m_ph[k][c] = (restart || wrapped) ? 0 : m_ph[k][c] + 1;
      m_run[k][c] = en[c];
    end
    m_err[k] = valid && rdy && rej;
    if (valid && rdy && !rej) begin
      m_pd[k][chan] = dv;
      m_pend[k][chan] = 1'b1;
    end
  endtask

  function automatic logic [4:0] e_slow(input int k);
    logic [4:0] r = '0;
    for (int c = 0; c < nch[k]; c++) r[c] = m_run[k][c] && (m_ph[k][c] < m_d[k][c] / 2);
    return r;
  endfunction

  function automatic logic [4:0] e_tick(input int k);
    logic [4:0] r = '0;
    for (int c = 0; c < nch[k]; c++) r[c] = m_run[k][c] && (m_ph[k][c] == m_d[k][c] - 1);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset(0);
      m_reset(1);
    end else begin
      m_step(0, {1'b0, a_en}, a_sync, a_valid, int'(a_chan), int'(a_div));
      m_step(1, b_en, b_sync, b_valid, int'(b_chan), int'(b_div));
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_slow",  {1'b0, a_slow}, e_slow(0));
      chk("a_tick",  {1'b0, a_tick}, e_tick(0));
      chk("a_ready", a_ready, m_ready(0, int'(a_chan)));
      chk("a_err",   a_err, m_err[0]);
      chk("b_slow",  b_slow, e_slow(1));
      chk("b_tick",  b_tick, e_tick(1));
      chk("b_ready", b_ready, m_ready(1, int'(b_chan)));
      chk("b_err",   b_err, m_err[1]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_a(input int ch, input int dv, output int waited);
    a_chan = 2'(ch); a_div = 16'(dv); a_valid = 1'b1; waited = 0;
    while (!a_ready && waited < 100) begin cyc(1); waited++; end
    if (!a_ready) chk("cfg_a_timeout", 0, 1);
    cyc(1);
    a_valid = 1'b0;
  endtask

  task automatic cfg_b(input int ch, input int dv, output int waited);
    b_chan = 3'(ch); b_div = 4'(dv); b_valid = 1'b1; waited = 0;
    while (!b_ready && waited < 100) begin cyc(1); waited++; end
    if (!b_ready) chk("cfg_b_timeout", 0, 1);
    cyc(1);
    b_valid = 1'b0;
  endtask

  initial begin
    int w, n, h, t;
    m_reset(0);
    m_reset(1);
    chk_on = 1'b1;
    cyc(2);
    chk("reset_slow", {a_slow, b_slow}, 0);
    chk("reset_tick", {a_tick, b_tick}, 0);
    chk("reset_ready", {a_ready, b_ready}, 2'b11);
    chk("reset_err", {a_err, b_err}, 0);
    rst_n = 1'b1;
    cyc(1);

    // ch0 at D=2: alternating slow, tick in the low cycle
    a_en = 4'b0001;
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      chk("d2_slow", a_slow[0], (i % 2 == 0));
      chk("d2_tick", a_tick[0], (i % 2 == 1));
      cyc(1);
    end

    // asynchronous reset between edges, while ch0 is high
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_slow", a_slow, 0);
    chk("async_rst_tick", a_tick, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);

    // reprogram ch1 to 5 while running, then a second write must wait for the apply
    a_en = 4'b0011;
    cyc(3);
    cfg_a(1, 5, w);
    cfg_a(1, 3, w);
    chk("pend_blocks_ready", (w > 0), 1);
    cfg_a(1, 5, w);
    cyc(20);

    // D=3 and D=7 aligned by sync
    cfg_a(2, 3, w);
    cfg_a(3, 7, w);
    a_en = 4'b1111;
    cyc(9);
    a_sync = 1'b1;
    cyc(1);
    a_sync = 1'b0;
    chk("sync_slow2", a_slow[2], 1);
    chk("sync_slow3", a_slow[3], 1);
    n = 0;
    while (!(a_tick[2] && a_tick[3]) && n < 40) begin cyc(1); n++; end
    chk("sync_coincide", n, 20);
    cyc(25);

    // rejected requests
    cfg_a(0, 1, w);
    chk("err_div1", a_err, 1);
    cyc(1);
    chk("err_single", a_err, 0);
    cfg_b(5, 7, w);
    chk("err_chan5", b_err, 1);
    cyc(3);

    // write to a disabled channel, then enable: 4-cycle period starting high
    cfg_b(1, 4, w);
    cyc(1);
    b_en[1] = 1'b1;
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      chk("dis_slow", b_slow[1], (i < 2));
      chk("dis_tick", b_tick[1], (i == 3));
      cyc(1);
    end

    // 4-bit counter at maximum D=15, and a write accepted on the wrap edge
    cfg_b(0, 15, w);
    cyc(1);
    b_en[0] = 1'b1;
    cyc(1);
    h = 0; t = 0;
    for (int i = 0; i < 15; i++) begin
      h += int'(b_slow[0]);
      t += int'(b_tick[0]);
      cyc(1);
    end
    chk("d15_high", h, 7);
    chk("d15_ticks", t, 1);
    n = 0;
    while (!b_tick[0] && n < 20) begin cyc(1); n++; end
    b_chan = 3'd0; b_div = 4'd5; b_valid = 1'b1;
    cyc(1);
    b_valid = 1'b0;
    n = 0;
    while (!b_tick[0] && n < 40) begin cyc(1); n++; end
    chk("wrap_write_late", n, 14);
    n = 0;
    do begin cyc(1); n++; end while (!b_tick[0] && n < 40);
    chk("wrap_write_period", n, 5);

    // randomized traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      a_valid = ($urandom % 3 == 0);
      a_chan  = 2'($urandom_range(0, 3));
      a_div   = 16'($urandom_range(0, 12));
      a_sync  = ($urandom % 50 == 0);
      if ($urandom % 40 == 0) a_en[$urandom_range(0, 3)] ^= 1'b1;
      b_valid = ($urandom % 3 == 0);
      b_chan  = 3'($urandom_range(0, 7));
      b_div   = 4'($urandom_range(0, 15));
      b_sync  = ($urandom % 50 == 0);
      if ($urandom % 40 == 0) b_en[$urandom_range(0, 4)] ^= 1'b1;
      cyc(1);
    end
    a_valid = 1'b0; b_valid = 1'b0; a_sync = 1'b0; b_sync = 1'b0;
    cyc(2);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
